note_lookup_arbiter: RTL and testbench

NOTE_LOOKUP_ARBITER -- requirements
Module: note_lookup_arbiter

---
 rtl/note_lookup_arbiter.sv | 132 +++++++++++++
 tb/tb_note_lookup_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// note_lookup_arbiter
//
// Time-shares one synchronous note-table ROM among NUM_CH sequencer channels.
// A request is granted round-robin, its note index is presented to the ROM for
// one cycle, and the returned phase delta is captured into that channel's slot
// of o_phase_delta. The channel is then acknowledged with a one-cycle pulse.
//
// State table:
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | scan unmasked requests from the RR pointer, latch grant + note
//   S_FETCH   | o_rom_en high, ROM reads the latched address
//   S_CAPTURE | ROM data valid; write it into the granted slot, raise ack
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_req          per-channel lookup request (level, held until o_ack)
//   i_note         per-channel note index, ch0 in the low NOTE_W bits
//   o_ack          one-cycle acknowledge per channel
//   o_rom_en       note-table read enable (FETCH only)
//   o_rom_addr     note-table read address (holds outside FETCH)
//   i_rom_data     note-table read data, valid the cycle after o_rom_en
//   o_phase_delta  registered per-channel phase delta, ch0 in the low bits
//   o_delta_valid  one-cycle pulse: channel delta updated this cycle
// -----------------------------------------------------------------------------
module note_lookup_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int NOTE_W  = 6,
    parameter int DELTA_W = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_CH-1:0]           i_req,
    input  logic [NUM_CH*NOTE_W-1:0]    i_note,
    output logic [NUM_CH-1:0]           o_ack,
    output logic                        o_rom_en,
    output logic [NOTE_W-1:0]           o_rom_addr,
    input  logic [DELTA_W-1:0]          i_rom_data,
    output logic [NUM_CH*DELTA_W-1:0]   o_phase_delta,
    output logic [NUM_CH-1:0]           o_delta_valid
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CH_W-1:0]   ptr_q;
    logic [CH_W-1:0]   grant_q;
    logic [CH_W-1:0]   grant_idx;
    logic              grant_found;
    logic [NUM_CH-1:0] req_masked;
    int unsigned       cand;

    // The channel being acked this cycle may still hold its request for one
    // more cycle; masking it here prevents a duplicate lookup.
    assign req_masked = i_req & ~o_ack;

    // Round-robin search: first unmasked request at or after the pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        cand        = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (int'(ptr_q) + i) % NUM_CH;
            if (!grant_found && req_masked[cand]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(cand);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        o_rom_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                o_rom_en = 1'b1;
                state_d  = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            o_ack         <= '0;
            o_delta_valid <= '0;
            o_rom_addr    <= '0;
            o_phase_delta <= '0;
        end else begin
            state_q       <= state_d;
            o_ack         <= '0;
            o_delta_valid <= '0;

            // Grant and note are latched together so later request/note
            // changes cannot disturb the lookup in flight.
            if (state_q == S_IDLE && grant_found) begin
                grant_q    <= grant_idx;
                o_rom_addr <= i_note[int'(grant_idx)*NOTE_W +: NOTE_W];
                ptr_q      <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
            end

            if (state_q == S_CAPTURE) begin
                o_phase_delta[int'(grant_q)*DELTA_W +: DELTA_W] <= i_rom_data;
                o_ack[grant_q]         <= 1'b1;
                o_delta_valid[grant_q] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_note_lookup_arbiter.sv
module tb_note_lookup_arbiter;

    localparam int NUM_CH  = 4;
    localparam int NOTE_W  = 6;
    localparam int DELTA_W = 32;

    logic                        i_clk;
    logic                        i_rst;
    logic [NUM_CH-1:0]           i_req;
    logic [NUM_CH*NOTE_W-1:0]    i_note;
    logic [NUM_CH-1:0]           o_ack;
    logic                        o_rom_en;
    logic [NOTE_W-1:0]           o_rom_addr;
    logic [DELTA_W-1:0]          i_rom_data;
    logic [NUM_CH*DELTA_W-1:0]   o_phase_delta;
    logic [NUM_CH-1:0]           o_delta_valid;

    note_lookup_arbiter #(
        .NUM_CH (NUM_CH),
        .NOTE_W (NOTE_W),
        .DELTA_W(DELTA_W)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req        (i_req),
        .i_note       (i_note),
        .o_ack        (o_ack),
        .o_rom_en     (o_rom_en),
        .o_rom_addr   (o_rom_addr),
        .i_rom_data   (i_rom_data),
        .o_phase_delta(o_phase_delta),
        .o_delta_valid(o_delta_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Synchronous note-table ROM
    logic [DELTA_W-1:0] rom_table [64];
    logic [DELTA_W-1:0] rom_q = '0;
    always @(posedge i_clk) if (o_rom_en) rom_q <= rom_table[o_rom_addr];
    assign i_rom_data = rom_q;

    logic [NOTE_W-1:0] notes [NUM_CH];
    assign i_note = {notes[3], notes[2], notes[1], notes[0]};

    // Reference model state
    typedef struct {
        int                 ch;
        logic [NOTE_W-1:0]  note;
        logic [DELTA_W-1:0] delta;
        bit                 first;
        int                 issue_cyc;
    } exp_t;

    exp_t               exp_q[$];
    logic [DELTA_W-1:0] model_delta [NUM_CH];
    int                 model_ptr = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int en_cyc   = 0;
    int last_ack = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    function automatic logic [NUM_CH*DELTA_W-1:0] packed_model();
        logic [NUM_CH*DELTA_W-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*DELTA_W +: DELTA_W] = model_delta[c];
        return v;
    endfunction

    // Round-robin at transaction level: every held request is served once,
    // visited in ascending order starting at the pointer.
    task automatic push_expected(input logic [NUM_CH-1:0] reqs);
        bit first = 1'b1;
        exp_t e;
        int start = model_ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            int idx = (start + k) % NUM_CH;
            if (reqs[idx]) begin
                e.ch        = idx;
                e.note      = notes[idx];
                e.delta     = rom_table[notes[idx]];
                e.first     = first;
                e.issue_cyc = cyc;
                exp_q.push_back(e);
                first     = 1'b0;
                model_ptr = (idx + 1) % NUM_CH;
            end
        end
    endtask

    // Monitor / scoreboard
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_rom_en) begin
                if (exp_q.size() == 0) flag("spurious_rom_en");
                else begin
                    check("rom_addr", o_rom_addr, exp_q[0].note);
                    if (exp_q[0].first) check("rom_en_latency", cyc, exp_q[0].issue_cyc + 1);
                    en_cyc = cyc;
                end
            end
            if (o_ack != 0 || o_delta_valid != 0) begin
                if (exp_q.size() == 0) flag("spurious_ack");
                else begin
                    exp_t e;
                    logic [NUM_CH-1:0] oh;
                    e  = exp_q.pop_front();
                    oh = 4'b0001 << e.ch;
                    check("ack_onehot", o_ack, oh);
                    check("delta_valid", o_delta_valid, oh);
                    check("ack_latency", cyc, en_cyc + 2);
                    if (!e.first) check("ack_spacing", cyc - last_ack, 3);
                    model_delta[e.ch] = e.delta;
                    check("phase_delta", o_phase_delta, packed_model());
                end
                last_ack = cyc;
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_ack", o_ack, 0);
        check("rst_valid", o_delta_valid, 0);
        check("rst_rom_en", o_rom_en, 0);
        check("rst_rom_addr", o_rom_addr, 0);
        check("rst_phase_delta", o_phase_delta, 0);
    endtask

    task automatic run_batch(input logic [NUM_CH-1:0] reqs, input bit late, input bit do_reset);
        logic [NUM_CH-1:0] late_pend = '0;
        bit done_reset = 1'b0;
        int budget = 0;
        @(negedge i_clk);
        push_expected(reqs);
        i_req = reqs;
        while ((exp_q.size() != 0 || i_req != 0) && budget < 60) begin
            @(negedge i_clk);
            budget++;
            for (int c = 0; c < NUM_CH; c++) begin
                if (late_pend[c]) begin
                    i_req[c]     = 1'b0;
                    late_pend[c] = 1'b0;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (o_ack[c]) begin
                    if (late) late_pend[c] = 1'b1;
                    else      i_req[c]     = 1'b0;
                end
            end
            if (do_reset && !done_reset && o_rom_en) begin
                @(posedge i_clk);
                #1;
                i_rst = 1'b1;
                done_reset = 1'b1;
                exp_q.delete();
                for (int c = 0; c < NUM_CH; c++) model_delta[c] = '0;
                model_ptr = 0;
                @(negedge i_clk);
                check_reset_outputs();
                i_rst = 1'b0;
                push_expected(i_req);
            end
        end
        if (budget >= 60) begin
            flag("batch_timeout");
            exp_q.delete();
            i_req = '0;
        end
        repeat (6) @(negedge i_clk);
    endtask

    initial begin
        i_rst = 1'b1;
        i_req = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            notes[c]       = '0;
            model_delta[c] = '0;
        end
        for (int a = 0; a < 64; a++) rom_table[a] = $urandom;
        rom_table[5] = 32'h1234_5678;
        rom_table[9] = 32'hAAAA_AAAA;

        repeat (2) @(negedge i_clk);
        check_reset_outputs();
        i_rst = 1'b0;

        // All four requesting from reset: ch0..ch3, 3 cycles apart
        for (int c = 0; c < NUM_CH; c++) notes[c] = NOTE_W'($urandom_range(0, 63));
        run_batch(4'b1111, 1'b0, 1'b0);
        // Single request on ch0, note 5
        notes[0] = 6'd5;
        run_batch(4'b0001, 1'b0, 1'b0);
        // Pointer after ch2 wraps through ch3 to ch0 before ch2
        notes[2] = 6'd17;
        run_batch(4'b0100, 1'b0, 1'b0);
        notes[0] = 6'd33;
        run_batch(4'b0101, 1'b0, 1'b0);
        // Late drop on ch1, note 0 (rest)
        notes[1] = 6'd0;
        run_batch(4'b0010, 1'b1, 1'b0);
        // ch3 written, then ch0 lookup must leave ch3 alone
        notes[3] = 6'd9;
        run_batch(4'b1000, 1'b0, 1'b0);
        notes[0] = 6'd5;
        run_batch(4'b0001, 1'b0, 1'b0);
        // Reset during CAPTURE, requests held through reset
        notes[1] = 6'd21;
        notes[2] = 6'd42;
        run_batch(4'b0110, 1'b0, 1'b1);

        for (int t = 0; t < 25; t++) begin
            for (int c = 0; c < NUM_CH; c++) notes[c] = NOTE_W'($urandom_range(0, 63));
            run_batch(NUM_CH'($urandom_range(1, 15)), bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
